relay_register_file: RTL
========================

// Module: relay_register_file
// PURPOSE
// - Parametrised successor of the 8-register data/address register unit.
// - NUM_REGS DATA_W-bit registers on the data bus; pairs M=M1:M2 and XY=X:Y also
//   load from and drive the ADDR_W address bus.
// - Configurable bus-merge mode; built-in two-cycle 16-bit pair incrementer (XY/M <- pair+1).
// - Sits between the control sequencer and the data/address buses of the relay CPU.
// PARAMETERS
// - DATA_W    8  data bus / register width
// - NUM_REGS  8  register count, >=8; indices 0..7 fixed (A,B,C,D,M1,M2,X,Y), extras general
// - ADDR_W    16 address bus width, must equal 2*DATA_W
// - WIRED_OR  1  1: multiple selects OR onto a bus (relay behaviour); 0: conflict -> bus 0, flag
// PORTS
// - clk       in   1         clock, rising edge
// - rst       in   1         asynchronous, active-high reset
// - ld        in   NUM_REGS  per-register load from data_in
// - sel       in   NUM_REGS  per-register drive onto data_out
// - data_in   in   DATA_W    data bus value to load
// - data_out  out  DATA_W    merged data bus drive (registered)
// - ld_m      in   1         load M1:M2 from addr_in
// - ld_xy     in   1         load X:Y from addr_in
// - sel_m     in   1         drive M1:M2 onto addr_out
// - sel_xy    in   1         drive X:Y onto addr_out
// - addr_in   in   ADDR_W    address bus value to load
// - addr_out  out  ADDR_W    merged address bus drive (registered)
// - inc_req   in   1         start increment of pair chosen by inc_sel
// - inc_sel   in   1         0 = XY, 1 = M
// - inc_busy  out  1         increment in progress
// - inc_done  out  1         one-cycle pulse, pair written
// - inc_carry out  1         carry out of last increment (pair wrapped to 0)
// - conflict  out  1         registered, WIRED_OR=0 only: >1 select on a bus this cycle
// - err       out  1         sticky: write blocked by busy increment
// - err_clr   in   1         clear err
// BEHAVIOUR
// - Reset: all registers, data_out, addr_out, inc_busy, inc_done, inc_carry, conflict,
//   and err go to 0 immediately; FSM -> IDLE. Reset mid-increment abandons it, no write.
// - Bus drive: data_out/addr_out update on the clock edge from current sel and register
//   values (1-cycle latency). No select -> 0.
// - Read before write: a register loaded in the same cycle drives its old value.
// - Loads take effect on the edge. Higher priority wins within a pair:
//   inc writeback > ld_m/ld_xy > byte ld. The losing write is dropped.
// - FSM IDLE: inc_req -> capture tmp=pair+1 mod 2^ADDR_W and carry -> CAPTURE.
//   inc_busy=1 from the next edge.
// - FSM CAPTURE: addr_out forced to the pair's old value (relay INC sequencing),
//   overriding sel_m/sel_xy -> WRITE.
// - FSM WRITE: pair <= tmp, inc_carry <= carry, inc_done pulses -> IDLE.
// - Latency: request edge to pair update = 2 edges; inc_done visible 2 cycles after inc_req.
// - inc_req while busy is ignored; no queueing, no err.
// - While busy, any ld/ld_m/ld_xy hitting the target pair is dropped and sets err.
//   Loads to the other registers proceed.
// - err stays set until err_clr; err_clr and a new error in the same cycle -> err=1.
// - WIRED_OR=0 with >=2 selects on one bus: that bus drives 0 and conflict=1 that cycle.
//   Each bus is judged independently.
// STRUCTURE
// - Package relay_regs_pkg: reg index constants REG_A..REG_Y, pair enum {PAIR_XY, PAIR_M},
//   inc FSM state enum {IDLE, CAPTURE, WRITE}.
// - One sub-module: relay_bus_merge #(W, N).
//   - Inputs: N sources + N selects.
//   - Outputs: OR/conflict-resolved bus and conflict bit.
//   - Instantiated for data and address buses.
// - Register array and inc FSM live in the top.
// TESTING
// - Reset mid-op: ld A=0x5A, start inc, assert rst -> all outputs 0, registers 0, no inc_done.
// - Load/select: ld[REG_B] with data_in=0x3C, next cycle sel[REG_B] -> data_out=0x3C one edge later.
//   Same-cycle ld+sel of B -> old value.
// - Pairs: ld_xy addr_in=0x12FF -> X=0x12, Y=0xFF.
//   - inc_req inc_sel=0 -> inc_busy for 2 cycles, inc_done.
//   - XY=0x1300, inc_carry=0.
// - Wrap: M=0xFFFF, inc_sel=1 -> M=0x0000, inc_carry=1.
//   - ld[REG_M1] during busy -> dropped, err=1.
//   - err_clr -> err=0.
// - Merge modes:
//   - WIRED_OR=1, sel A(0xF0)+C(0x0F) -> data_out=0xFF.
//   - WIRED_OR=0 same -> data_out=0, conflict=1.
//   - sel_m+sel_xy judged on the address bus separately.
// - Priority: ld_xy=0xABCD with ld[REG_X] data 0x11 -> X=0xAB.
//   - inc_req while busy ignored: exactly one inc_done.

Source files
------------

// File: rtl/relay_regs_pkg.sv
// Shared constants and types for the relay CPU register file: fixed register
// indices, address-pair selector and increment sequencer states.
package relay_regs_pkg;

    localparam int REG_A  = 0;
    localparam int REG_B  = 1;
    localparam int REG_C  = 2;
    localparam int REG_D  = 3;
    localparam int REG_M1 = 4;
    localparam int REG_M2 = 5;
    localparam int REG_X  = 6;
    localparam int REG_Y  = 7;

    typedef enum logic {
        PAIR_XY = 1'b0,
        PAIR_M  = 1'b1
    } pairE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        WRITE   = 2'd2
    } incStateE;

endpackage

// File: rtl/relay_register_file_if.sv
// Sequencer-side bundle of the register file: data/address bus loads and
// drives, pair increment handshake and status flags.
interface relay_register_file_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 16
);
    logic [NUM_REGS-1:0] ld;
    logic [NUM_REGS-1:0] sel;
    logic [DATA_W-1:0]   data_in;
    logic [DATA_W-1:0]   data_out;
    logic                ld_m;
    logic                ld_xy;
    logic                sel_m;
    logic                sel_xy;
    logic [ADDR_W-1:0]   addr_in;
    logic [ADDR_W-1:0]   addr_out;
    logic                inc_req;
    logic                inc_sel;
    logic                inc_busy;
    logic                inc_done;
    logic                inc_carry;
    logic                conflict;
    logic                err;
    logic                err_clr;

    modport master (
        output ld, sel, data_in, ld_m, ld_xy, sel_m, sel_xy, addr_in,
               inc_req, inc_sel, err_clr,
        input  data_out, addr_out, inc_busy, inc_done, inc_carry, conflict, err
    );

    modport slave (
        input  ld, sel, data_in, ld_m, ld_xy, sel_m, sel_xy, addr_in,
               inc_req, inc_sel, err_clr,
        output data_out, addr_out, inc_busy, inc_done, inc_carry, conflict, err
    );

endinterface

// File: rtl/relay_bus_merge.sv
// Merges N selectable sources onto one W-bit bus, either wired-OR or with
// multi-select detection that blanks the bus.
module relay_bus_merge #(
    parameter int W        = 8,
    parameter int N        = 8,
    parameter int WIRED_OR = 1
) (
    input  logic [N-1:0][W-1:0] src,
    input  logic [N-1:0]        sel,
    output logic [W-1:0]        busOut,
    output logic                conflict
);

    logic [W-1:0] orBus;
    logic         multiSel;

    // Clearing the lowest set bit leaves something only if two or more are set
    assign multiSel = |(sel & (sel - N'(1)));

    // Wired-OR of every selected source
    always_comb begin
        orBus = '0;
        for (int i = 0; i < N; i++) begin
            orBus = orBus | (src[i] & {W{sel[i]}});
        end
    end

    // Conflict resolution in strict mode
    always_comb begin
        if ((WIRED_OR == 0) && multiSel) begin
            busOut   = '0;
            conflict = 1'b1;
        end else begin
            busOut   = orBus;
            conflict = 1'b0;
        end
    end

endmodule

// File: rtl/relay_register_file.sv
// Data/address register unit of the relay CPU: byte registers, M and XY
// address pairs, registered bus drives and a two-step pair incrementer.
module relay_register_file
    import relay_regs_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 16,
    parameter int WIRED_OR = 1
) (
    input  logic clk,
    input  logic rst,
    relay_register_file_if.slave bus
);

    logic [DATA_W-1:0]                 regFile [NUM_REGS];
    logic [DATA_W-1:0]                 wrData  [NUM_REGS];
    logic [NUM_REGS-1:0]               wrEn;
    logic [NUM_REGS-1:0][DATA_W-1:0]   dataSrc;
    logic [1:0][ADDR_W-1:0]            addrSrc;
    logic [1:0]                        addrSel;
    logic [DATA_W-1:0]                 dataMerged;
    logic [ADDR_W-1:0]                 addrMerged;
    logic                              dataConflict;
    logic                              addrConflict;

    incStateE          state;
    incStateE          stateNext;
    pairE              incPairR;
    logic [ADDR_W-1:0] incTmpR;
    logic              incCarryTmpR;

    logic [ADDR_W-1:0] pairXy;
    logic [ADDR_W-1:0] pairM;
    logic [ADDR_W-1:0] targetVal;
    logic [ADDR_W-1:0] reqVal;
    logic              busy;
    logic              blockM;
    logic              blockXy;
    logic              wbM;
    logic              wbXy;
    logic              errSet;

    logic [DATA_W-1:0] dataOutR;
    logic [ADDR_W-1:0] addrOutR;
    logic              incBusyR;
    logic              incDoneR;
    logic              incCarryR;
    logic              conflictR;
    logic              errR;

    assign pairXy    = {regFile[REG_X], regFile[REG_Y]};
    assign pairM     = {regFile[REG_M1], regFile[REG_M2]};
    assign targetVal = (incPairR == PAIR_M) ? pairM : pairXy;
    assign reqVal    = bus.inc_sel ? pairM : pairXy;
    assign busy      = (state != IDLE);
    assign blockM    = busy && (incPairR == PAIR_M);
    assign blockXy   = busy && (incPairR == PAIR_XY);
    assign wbM       = (state == WRITE) && (incPairR == PAIR_M);
    assign wbXy      = (state == WRITE) && (incPairR == PAIR_XY);

    // Write steering: byte load < pair load < busy block < increment writeback
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            wrEn[i]   = bus.ld[i];
            wrData[i] = bus.data_in;
        end
        wrEn[REG_M1]   = bus.ld[REG_M1] | bus.ld_m;
        wrEn[REG_M2]   = bus.ld[REG_M2] | bus.ld_m;
        wrEn[REG_X]    = bus.ld[REG_X]  | bus.ld_xy;
        wrEn[REG_Y]    = bus.ld[REG_Y]  | bus.ld_xy;
        wrData[REG_M1] = bus.ld_m  ? bus.addr_in[ADDR_W-1:DATA_W] : bus.data_in;
        wrData[REG_M2] = bus.ld_m  ? bus.addr_in[DATA_W-1:0]      : bus.data_in;
        wrData[REG_X]  = bus.ld_xy ? bus.addr_in[ADDR_W-1:DATA_W] : bus.data_in;
        wrData[REG_Y]  = bus.ld_xy ? bus.addr_in[DATA_W-1:0]      : bus.data_in;

        errSet = (blockM  && (wrEn[REG_M1] || wrEn[REG_M2])) ||
                 (blockXy && (wrEn[REG_X]  || wrEn[REG_Y]));

        wrEn[REG_M1] = (wrEn[REG_M1] & ~blockM)  | wbM;
        wrEn[REG_M2] = (wrEn[REG_M2] & ~blockM)  | wbM;
        wrEn[REG_X]  = (wrEn[REG_X]  & ~blockXy) | wbXy;
        wrEn[REG_Y]  = (wrEn[REG_Y]  & ~blockXy) | wbXy;
        wrData[REG_M1] = wbM  ? incTmpR[ADDR_W-1:DATA_W] : wrData[REG_M1];
        wrData[REG_M2] = wbM  ? incTmpR[DATA_W-1:0]      : wrData[REG_M2];
        wrData[REG_X]  = wbXy ? incTmpR[ADDR_W-1:DATA_W] : wrData[REG_X];
        wrData[REG_Y]  = wbXy ? incTmpR[DATA_W-1:0]      : wrData[REG_Y];
    end

    // Register array
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regFile[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wrEn[i]) begin
                    regFile[i] <= wrData[i];
                end
            end
        end
    end

    // Bus sources; during CAPTURE the address bus is owned by the incrementer
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            dataSrc[i] = regFile[i];
        end
        addrSrc = {pairM, pairXy};
        addrSel = (state == CAPTURE) ? 2'b00 : {bus.sel_m, bus.sel_xy};
    end

    relay_bus_merge #(.W(DATA_W), .N(NUM_REGS), .WIRED_OR(WIRED_OR)) uDataMerge (
        .src      (dataSrc),
        .sel      (bus.sel),
        .busOut   (dataMerged),
        .conflict (dataConflict)
    );

    relay_bus_merge #(.W(ADDR_W), .N(2), .WIRED_OR(WIRED_OR)) uAddrMerge (
        .src      (addrSrc),
        .sel      (addrSel),
        .busOut   (addrMerged),
        .conflict (addrConflict)
    );

    // Increment sequencer next state
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = bus.inc_req ? CAPTURE : IDLE;
            CAPTURE: stateNext = WRITE;
            WRITE:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Increment sequencer state, operand capture and handshake flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            incPairR     <= PAIR_XY;
            incTmpR      <= '0;
            incCarryTmpR <= 1'b0;
            incBusyR     <= 1'b0;
            incDoneR     <= 1'b0;
            incCarryR    <= 1'b0;
        end else begin
            state    <= stateNext;
            incBusyR <= (stateNext != IDLE);
            incDoneR <= (state == WRITE);
            if ((state == IDLE) && bus.inc_req) begin
                incPairR                <= pairE'(bus.inc_sel);
                {incCarryTmpR, incTmpR} <= {1'b0, reqVal} + (ADDR_W + 1)'(1);
            end
            if (state == WRITE) begin
                incCarryR <= incCarryTmpR;
            end
        end
    end

    // Registered bus drives and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataOutR  <= '0;
            addrOutR  <= '0;
            conflictR <= 1'b0;
            errR      <= 1'b0;
        end else begin
            dataOutR  <= dataMerged;
            addrOutR  <= (state == CAPTURE) ? targetVal : addrMerged;
            conflictR <= dataConflict | addrConflict;
            errR      <= errSet | (errR & ~bus.err_clr);
        end
    end

    assign bus.data_out  = dataOutR;
    assign bus.addr_out  = addrOutR;
    assign bus.inc_busy  = incBusyR;
    assign bus.inc_done  = incDoneR;
    assign bus.inc_carry = incCarryR;
    assign bus.conflict  = conflictR;
    assign bus.err       = errR;

endmodule
